// File: rtl/pwm_test.sv
// pwm_test: breathing-LED PWM; a phase-accumulator compare whose duty ramps
// linearly up to full scale and back down, forever.
`timescale 1ns/1ps
module pwm_test #(
  parameter int N           = 32,
  parameter int PERIOD_WORD = 21475,
  parameter int STEP_CYCLES = 200000,
  parameter int DUTY_STEP   = 4294967
) (
  input  logic sys_clk_p,
  input  logic sys_clk_n,
  input  logic rst_n,
  output logic led
);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [N-1:0]  INC  = N'(PERIOD_WORD);
  localparam logic [N-1:0]  STEP = N'(DUTY_STEP);
  localparam logic [N-1:0]  MAX  = '1;
  localparam logic [SW-1:0] LAST = SW'(STEP_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;
  // The differential pair feeds an IBUFDS on the board; behaviourally the buffer output is the p leg.
  logic clk, unused_clk_n;
  assign clk = sys_clk_p;
  assign unused_clk_n = sys_clk_n;
  logic [N-1:0]  period_cnt_q, period_cnt_d, duty_q, duty_d;
  logic [SW-1:0] step_cnt_q, step_cnt_d;
  state_t        state_q, state_d;
  logic          led_q, led_d, tick;
  always_comb begin
    period_cnt_d = period_cnt_q + INC;
    tick         = step_cnt_q == LAST;
    step_cnt_d   = tick ? '0 : step_cnt_q + 1'b1;
    led_d        = period_cnt_q < duty_q;
    duty_d       = duty_q;
    state_d      = state_q;
    // Saturation is tested before the add/subtract so duty never wraps.
    if (state_q == IDLE) state_d = UP;
    else if (tick && state_q == UP) begin
      if (duty_q > MAX - STEP) begin
        duty_d  = MAX;
        state_d = DOWN;
      end else duty_d = duty_q + STEP;
    end else if (tick && state_q == DOWN) begin
      if (duty_q < STEP) begin
        duty_d  = '0;
        state_d = UP;
      end else duty_d = duty_q - STEP;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q <= '0;
      duty_q       <= '0;
      step_cnt_q   <= '0;
      state_q      <= IDLE;
      led_q        <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      duty_q       <= duty_d;
      step_cnt_q   <= step_cnt_d;
      state_q      <= state_d;
      led_q        <= led_d;
    end
  end
  assign led = led_q;
endmodule

// File: tb/tb_pwm_test.sv
// tb_pwm_test: small-parameter PWM ramp checked cycle by cycle via a scoreboard,
// plus async reset mid-ramp and a default-parameter accumulator spot check.
`timescale 1ns/1ps
module tb_pwm_test;
  logic sys_clk_p = 1'b0;
  logic sys_clk_n;
  logic rst_n = 1'b0;
  logic led, led_def;
  int total = 0, bad = 0;
  logic [7:0] dseq [8] = '{8'd64, 8'd128, 8'd192, 8'd255, 8'd191, 8'd127, 8'd63, 8'd0};

  assign sys_clk_n = ~sys_clk_p;
  always #2.5 sys_clk_p = ~sys_clk_p;

  pwm_test #(.N(8), .PERIOD_WORD(16), .STEP_CYCLES(32), .DUTY_STEP(64)) dut (
    .sys_clk_p(sys_clk_p), .sys_clk_n(sys_clk_n), .rst_n(rst_n), .led(led));

  pwm_test dut_def (
    .sys_clk_p(sys_clk_p), .sys_clk_n(sys_clk_n), .rst_n(rst_n), .led(led_def));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Edge k after reset release: period = 16k mod 256, duty changes every 32 edges,
  // led after edge k+1 = (period after k < duty after k).
  task automatic run(input int edges);
    logic       exp_q [$];
    logic [7:0] d;
    d = 8'd0;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int k = 1; k <= edges; k++) begin
      @(posedge sys_clk_p);
      #1;
      if (exp_q.size() > 0) check($sformatf("led@%0d", k), 32'(led), 32'(exp_q.pop_front()));
      if (k % 32 == 0) begin
        d = dseq[(k / 32 - 1) % 8];
        check($sformatf("duty@%0d", k), 32'(dut.duty_q), 32'(d));
      end
      exp_q.push_back(((16 * k) % 256) < int'(d));
    end
  endtask

  initial begin
    #1;
    check("rst_led", 32'(led), 32'd0);
    check("rst_duty", 32'(dut.duty_q), 32'd0);
    #50;
    check("rst_led_mid", 32'(led), 32'd0);
    check("rst_def_led", 32'(led_def), 32'd0);
    check("rst_def_period", dut_def.period_cnt_q, 32'd0);
    #50;
    rst_n = 1'b1;
    run(165);
    check("def_period", dut_def.period_cnt_q, 32'(165 * 21475));
    check("def_led", 32'(led_def), 32'd0);
    check("pre_rst_led", 32'(led), 32'd1);
    check("pre_rst_duty", 32'(dut.duty_q), 32'd191);
    #0.5;
    rst_n = 1'b0;
    #0.2;
    check("async_led", 32'(led), 32'd0);
    check("async_duty", 32'(dut.duty_q), 32'd0);
    check("async_period", 32'(dut.period_cnt_q), 32'd0);
    @(posedge sys_clk_p);
    #1;
    check("hold_led", 32'(led), 32'd0);
    @(negedge sys_clk_p);
    #0.5;
    rst_n = 1'b1;
    run(300);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
